bcd_countdown_timer: RTL and testbench

- 4-digit BCD down-counter (0000-9999) that runs from a preloaded value to 0000, one count per cycle in which `tick` is high.
- Complement to the team's up-counting BCD digit counter. Used as an event/timeout countdown driven by the same slow-enable tick fabric.
- Exposes per-digit borrow enables, mirroring the up-counter's carry enables.
- Small control FSM with load/start/stop and a one-cycle `done` pulse.

---
 rtl/bcd_countdown_timer.sv | 134 +++++++++++++
 tb/tb_bcd_countdown_timer.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/bcd_countdown_timer.sv
`default_nettype none
// ============================================================================
//  Module      : bcd_countdown_timer
//  Description : Multi-digit BCD down-counter with load/start/stop control,
//                per-digit borrow enables and a one-cycle done pulse.
//  Revision    : 1.0 - initial release
// ============================================================================
module bcd_countdown_timer #(
    parameter int NDIG = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                load,
    input  logic [4*NDIG-1:0]   load_val,
    input  logic                start,
    input  logic                stop,
    input  logic                tick,
    output logic [4*NDIG-1:0]   q,
    output logic [NDIG-1:1]     borrow,
    output logic                running,
    output logic                done,
    output logic                clamped
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [4*NDIG-1:0] c_zero = '0;
    localparam logic [4*NDIG-1:0] c_one  = {{(4*NDIG-1){1'b0}}, 1'b1};

    state_t              r_state;
    logic [4*NDIG-1:0]   r_q;
    logic                r_running;
    logic                r_done;
    logic                r_clamped;

    logic                w_dec;
    logic [NDIG-1:0]     w_digit_en;
    logic [NDIG-1:0]     w_clip;
    logic [4*NDIG-1:0]   w_q_dec;
    logic [4*NDIG-1:0]   w_load_sat;

    // A decrement only happens in RUN when nothing of higher priority is active
    assign w_dec = (r_state == S_RUN) & tick & ~load & ~stop & ~reset;

    // Digit 0 steps on every decrement; higher digits step when all lower digits are zero
    assign w_digit_en[0] = w_dec;

    genvar gi;
    generate
        for (gi = 1; gi < NDIG; gi++) begin : g_borrow
            assign w_digit_en[gi] = w_dec & (r_q[4*gi-1:0] == '0);
        end

        for (gi = 0; gi < NDIG; gi++) begin : g_digit
            logic [3:0] w_cur;
            logic [3:0] w_ld;
            assign w_cur = r_q[4*gi +: 4];
            assign w_ld  = load_val[4*gi +: 4];
            // Per-digit decrement with 0 -> 9 wrap
            assign w_q_dec[4*gi +: 4] = !w_digit_en[gi] ? w_cur :
                                        (w_cur == 4'd0) ? 4'd9 : (w_cur - 4'd1);
            // Non-BCD preload digits saturate to 9
            assign w_clip[gi]            = (w_ld > 4'd9);
            assign w_load_sat[4*gi +: 4] = w_clip[gi] ? 4'd9 : w_ld;
        end
    endgenerate

    assign borrow = w_digit_en[NDIG-1:1];

    // Control FSM, count register and registered status outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_q       <= c_zero;
            r_running <= 1'b0;
            r_done    <= 1'b0;
            r_clamped <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (load) begin
                r_q       <= w_load_sat;
                r_clamped <= |w_clip;
                r_state   <= S_IDLE;
                r_running <= 1'b0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (!stop && start) begin
                            if (r_q != c_zero) begin
                                r_state   <= S_RUN;
                                r_running <= 1'b1;
                            end else begin
                                // Starting at zero completes immediately
                                r_state <= S_DONE;
                                r_done  <= 1'b1;
                            end
                        end
                    end
                    S_RUN: begin
                        if (stop) begin
                            r_state   <= S_IDLE;
                            r_running <= 1'b0;
                        end else if (w_dec) begin
                            r_q <= w_q_dec;
                            if (r_q == c_one) begin
                                r_state   <= S_DONE;
                                r_running <= 1'b0;
                                r_done    <= 1'b1;
                            end
                        end
                    end
                    S_DONE: begin
                        r_state <= S_IDLE;
                    end
                    default: begin
                        r_state   <= S_IDLE;
                        r_running <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign q       = r_q;
    assign running = r_running;
    assign done    = r_done;
    assign clamped = r_clamped;

endmodule
`default_nettype wire

// File: tb/tb_bcd_countdown_timer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_bcd_countdown_timer
//  Description : Table-driven self-checking bench for bcd_countdown_timer.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_bcd_countdown_timer;

    logic        clk;
    logic        reset;
    logic        load;
    logic [15:0] load_val;
    logic        start;
    logic        stop;
    logic        tick;
    logic [15:0] q;
    logic [3:1]  borrow;
    logic        running;
    logic        done;
    logic        clamped;

    bcd_countdown_timer #(.NDIG(4)) dut (
        .clk      (clk),
        .reset    (reset),
        .load     (load),
        .load_val (load_val),
        .start    (start),
        .stop     (stop),
        .tick     (tick),
        .q        (q),
        .borrow   (borrow),
        .running  (running),
        .done     (done),
        .clamped  (clamped)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        ld;
        logic [15:0] lv;
        logic        st;
        logic        sp;
        logic        tk;
        logic [15:0] eq;
        logic        er;
        logic        ed;
        logic        ec;
        logic [2:0]  eb;
    } vec_t;

    vec_t tbl[$];
    vec_t sb[$];
    int   n_pass  = 0;
    int   n_total = 0;

    function automatic vec_t mk(logic rst, logic ld, logic [15:0] lv, logic st,
                                logic sp, logic tk, logic [15:0] eq, logic er,
                                logic ed, logic ec, logic [2:0] eb);
        vec_t v;
        v.rst = rst; v.ld = ld; v.lv = lv; v.st = st; v.sp = sp; v.tk = tk;
        v.eq = eq; v.er = er; v.ed = ed; v.ec = ec; v.eb = eb;
        return v;
    endfunction

    // Plain-integer reference for the long tick run
    function automatic logic [15:0] to_bcd(int v);
        logic [15:0] r;
        r[3:0]   = 4'((v)        % 10);
        r[7:4]   = 4'((v / 10)   % 10);
        r[11:8]  = 4'((v / 100)  % 10);
        r[15:12] = 4'((v / 1000) % 10);
        return r;
    endfunction

    function automatic logic [2:0] borrow_of(int v);
        logic [2:0] b;
        b[0] = (v % 10   == 0);
        b[1] = (v % 100  == 0);
        b[2] = (v % 1000 == 0);
        return b;
    endfunction

    task automatic check(input string nm, input int row, input logic [15:0] got,
                         input logic [15:0] exp);
        n_total++;
        if (got !== exp)
            $display("FAIL %s row %0d: got %h expected %h", nm, row, got, exp);
        else
            n_pass++;
    endtask

    task automatic apply(input vec_t v, input int row);
        vec_t e;
        @(negedge clk);
        reset = v.rst; load = v.ld; load_val = v.lv;
        start = v.st;  stop = v.sp; tick = v.tk;
        sb.push_back(v);
        #1;
        check("borrow", row, {13'd0, borrow}, {13'd0, v.eb});
        @(posedge clk);
        #1;
        e = sb.pop_front();
        check("q",       row, q,                e.eq);
        check("running", row, {15'd0, running}, {15'd0, e.er});
        check("done",    row, {15'd0, done},    {15'd0, e.ed});
        check("clamped", row, {15'd0, clamped}, {15'd0, e.ec});
    endtask

    initial begin
        int cur;
        reset = 1'b1; load = 1'b0; load_val = 16'h0; start = 1'b0; stop = 1'b0; tick = 1'b0;

        // reset state
        tbl.push_back(mk(1,0,16'h0000,0,0,0, 16'h0000,0,0,0,3'b000));
        // 0003 countdown with ticks spaced 4 cycles apart
        tbl.push_back(mk(0,1,16'h0003,0,0,0, 16'h0003,0,0,0,3'b000));
        tbl.push_back(mk(0,0,16'h0000,1,0,0, 16'h0003,1,0,0,3'b000));
        for (int t = 2; t >= 0; t--) begin
            tbl.push_back(mk(0,0,16'h0,0,0,1, to_bcd(t), (t != 0), (t == 0), 0, 3'b000));
            for (int k = 0; k < 3; k++)
                tbl.push_back(mk(0,0,16'h0,0,0,0, to_bcd(t), (t != 0), 0, 0, 3'b000));
        end
        // 1000 -> 0999 with full borrow ripple, then 99 continuous ticks to 0900
        tbl.push_back(mk(0,1,16'h1000,0,0,0, 16'h1000,0,0,0,3'b000));
        tbl.push_back(mk(0,0,16'h0000,1,0,0, 16'h1000,1,0,0,3'b000));
        tbl.push_back(mk(0,0,16'h0000,0,0,1, 16'h0999,1,0,0,3'b111));
        cur = 999;
        for (int k = 0; k < 99; k++) begin
            tbl.push_back(mk(0,0,16'h0,0,0,1, to_bcd(cur - 1), 1, 0, 0, borrow_of(cur)));
            cur--;
        end
        tbl.push_back(mk(0,0,16'h0000,0,1,0, 16'h0900,0,0,0,3'b000));
        // stop wins over tick, then resume
        tbl.push_back(mk(0,1,16'h0205,0,0,0, 16'h0205,0,0,0,3'b000));
        tbl.push_back(mk(0,0,16'h0000,1,0,0, 16'h0205,1,0,0,3'b000));
        tbl.push_back(mk(0,0,16'h0000,0,1,1, 16'h0205,0,0,0,3'b000));
        tbl.push_back(mk(0,0,16'h0000,1,0,0, 16'h0205,1,0,0,3'b000));
        tbl.push_back(mk(0,0,16'h0000,0,0,1, 16'h0204,1,0,0,3'b000));
        // clamping of non-BCD digits
        tbl.push_back(mk(0,1,16'hA5F3,0,0,0, 16'h9593,0,0,1,3'b000));
        tbl.push_back(mk(0,1,16'h0012,0,0,0, 16'h0012,0,0,0,3'b000));
        // start at zero pulses done once
        tbl.push_back(mk(0,1,16'h0000,0,0,0, 16'h0000,0,0,0,3'b000));
        tbl.push_back(mk(0,0,16'h0000,1,0,0, 16'h0000,0,1,0,3'b000));
        tbl.push_back(mk(0,0,16'h0000,0,0,0, 16'h0000,0,0,0,3'b000));
        // load aborts at 0001 with tick: no done
        tbl.push_back(mk(0,1,16'h0001,0,0,0, 16'h0001,0,0,0,3'b000));
        tbl.push_back(mk(0,0,16'h0000,1,0,0, 16'h0001,1,0,0,3'b000));
        tbl.push_back(mk(0,1,16'h0042,0,0,1, 16'h0042,0,0,0,3'b000));
        tbl.push_back(mk(0,0,16'h0000,0,0,0, 16'h0042,0,0,0,3'b000));
        // reset mid-countdown clears everything including clamped
        tbl.push_back(mk(0,1,16'h0A50,0,0,0, 16'h0950,0,0,1,3'b000));
        tbl.push_back(mk(0,0,16'h0000,1,0,0, 16'h0950,1,0,1,3'b000));
        tbl.push_back(mk(0,0,16'h0000,0,0,1, 16'h0949,1,0,1,3'b001));
        tbl.push_back(mk(1,0,16'h0000,0,0,1, 16'h0000,0,0,0,3'b000));
        tbl.push_back(mk(0,0,16'h0000,0,0,1, 16'h0000,0,0,0,3'b000));
        tbl.push_back(mk(0,0,16'h0000,0,0,1, 16'h0000,0,0,0,3'b000));
        tbl.push_back(mk(0,1,16'h0003,0,0,0, 16'h0003,0,0,0,3'b000));
        tbl.push_back(mk(0,0,16'h0000,1,0,0, 16'h0003,1,0,0,3'b000));
        tbl.push_back(mk(0,0,16'h0000,0,0,1, 16'h0002,1,0,0,3'b000));

        for (int i = 0; i < tbl.size(); i++)
            apply(tbl[i], i);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
